// File: rtl/fma_pkg.sv
// Shared definitions for the FMA array: lane defaults and the writeback state type.
package fma_pkg;

    localparam int DEFAULT_WIDTH     = 16;
    localparam int DEFAULT_FMA_COUNT = 4;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } wb_state_t;

endpackage

// File: rtl/fma_writeback_buffer.sv
// Gathers one result per FMA lane in any order, then bursts them to memory
// lane 0 first at consecutive word addresses over a valid/ready port.
module fma_writeback_buffer
    import fma_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int FMA_COUNT  = DEFAULT_FMA_COUNT,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [FMA_COUNT*WIDTH-1:0] result_in,
    input  logic [FMA_COUNT-1:0]       result_valid_in,
    input  logic [ADDR_WIDTH-1:0]      base_addr_in,
    output logic [WIDTH-1:0]           data_out,
    output logic [ADDR_WIDTH-1:0]      addr_out,
    output logic                       valid_out,
    input  logic                       ready_in,
    output logic                       busy_out,
    output logic                       drop_out
);

    localparam int IDX_W = (FMA_COUNT > 1) ? $clog2(FMA_COUNT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FMA_COUNT - 1);

    wb_state_t              state_q, state_d;
    logic [FMA_COUNT-1:0]   full_q, full_d;
    logic [WIDTH-1:0]       slot_q [FMA_COUNT];
    logic [WIDTH-1:0]       slot_d [FMA_COUNT];
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   valid_q, valid_d;
    logic                   drop_q, drop_d;

    always_comb begin
        state_d = state_q;
        full_d  = full_q;
        slot_d  = slot_q;
        idx_d   = idx_q;
        data_d  = data_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        drop_d  = 1'b0;

        case (state_q)
            COLLECT: begin
                // First report per lane wins; repeats are discarded and flagged.
                for (int i = 0; i < FMA_COUNT; i++) begin
                    if (result_valid_in[i]) begin
                        if (full_q[i]) begin
                            drop_d = 1'b1;
                        end else begin
                            full_d[i] = 1'b1;
                            slot_d[i] = result_in[i*WIDTH +: WIDTH];
                        end
                    end
                end
                // Beat 0 is presented on the completing edge, so it must come
                // from the next-state slot in case lane 0 lands on that edge.
                if (&full_d) begin
                    state_d = DRAIN;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    data_d  = slot_d[0];
                    addr_d  = base_addr_in;
                end
            end
            DRAIN: begin
                drop_d = |result_valid_in;
                if (ready_in) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = COLLECT;
                        full_d  = '0;
                        valid_d = 1'b0;
                        idx_d   = '0;
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        data_d = slot_q[idx_d];
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= COLLECT;
            full_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
            for (int i = 0; i < FMA_COUNT; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            full_q  <= full_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
            for (int i = 0; i < FMA_COUNT; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    assign data_out  = data_q;
    assign addr_out  = addr_q;
    assign valid_out = valid_q;
    assign busy_out  = (state_q == DRAIN);
    assign drop_out  = drop_q;

endmodule

// File: tb/tb_fma_writeback_buffer.sv
// Scoreboard bench for fma_writeback_buffer: directed scenarios then random traffic.
module tb_fma_writeback_buffer;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int AW = 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*W-1:0]  result = '0;
    logic [N-1:0]    rvalid = '0;
    logic [AW-1:0]   base = '0;
    logic            ready = 1'b0;
    logic [W-1:0]    data_o;
    logic [AW-1:0]   addr_o;
    logic            valid_o;
    logic            busy_o;
    logic            drop_o;

    int n_cmp = 0;
    int n_bad = 0;

    fma_writeback_buffer #(.WIDTH(W), .FMA_COUNT(N), .ADDR_WIDTH(AW)) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .result_in       (result),
        .result_valid_in (rvalid),
        .base_addr_in    (base),
        .data_out        (data_o),
        .addr_out        (addr_o),
        .valid_out       (valid_o),
        .ready_in        (ready),
        .busy_out        (busy_o),
        .drop_out        (drop_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: lanes hold at most one pending value; a completed set
    // becomes N expected beats; the burst then lasts N ready-high edges.
    beat_t        exp_q[$];
    logic [W-1:0] m_slot [N];
    bit   [N-1:0] m_full = '0;
    bit           m_drain = 0;
    int           m_left = 0;
    bit           m_drop = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_full  = '0;
            m_drain = 0;
            m_left  = 0;
            m_drop  = 0;
            exp_q.delete();
        end else if (!m_drain) begin
            m_drop = 0;
            for (int i = 0; i < N; i++) begin
                if (rvalid[i]) begin
                    if (m_full[i]) m_drop = 1;
                    else begin
                        m_full[i] = 1;
                        m_slot[i] = result[i*W +: W];
                    end
                end
            end
            if (&m_full) begin
                for (int k = 0; k < N; k++) begin
                    beat_t b;
                    b.addr = base + AW'(k);
                    b.data = m_slot[k];
                    exp_q.push_back(b);
                end
                m_drain = 1;
                m_left  = N;
            end
        end else begin
            m_drop = |rvalid;
            if (ready) m_left--;
            if (m_left == 0) begin
                m_drain = 0;
                m_full  = '0;
            end
        end
    end

    // Monitor: outputs are sampled mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("valid_out", 32'(valid_o), 32'(m_drain));
            chk("busy_out", 32'(busy_o), 32'(m_drain));
            chk("drop_out", 32'(drop_o), 32'(m_drop));
            if (valid_o && ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'(addr_o), 32'hFFFF_FFFF);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_addr", 32'(addr_o), 32'(e.addr));
                    chk("beat_data", 32'(data_o), 32'(e.data));
                end
            end
        end
    end

    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] r,
                        input logic [AW-1:0] b, input logic rdy);
        rvalid = v;
        result = r;
        base   = b;
        ready  = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) step('0, '0, '0, 1'b1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 32'(valid_o), 32'd0);
        chk({tag, "_busy"},  32'(busy_o),  32'd0);
        chk({tag, "_drop"},  32'(drop_o),  32'd0);
        chk({tag, "_data"},  32'(data_o),  32'd0);
        chk({tag, "_addr"},  32'(addr_o),  32'd0);
    endtask

    task automatic scen1();
        step(4'b0001, 64'h0000_0000_0000_0011, 8'h10, 1'b1);
        step(4'b0010, 64'h0000_0000_0022_0000, 8'h10, 1'b1);
        step(4'b0100, 64'h0000_0033_0000_0000, 8'h10, 1'b1);
        step(4'b1000, 64'h0044_0000_0000_0000, 8'h10, 1'b1);
        idle(6);
    endtask

    initial begin
        #1;
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        scen1();

        // All lanes at once, addresses wrap past FF.
        step(4'hF, 64'hA003_A002_A001_A000, 8'hFE, 1'b1);
        idle(6);

        // Duplicate report on lane 2 is dropped; first value kept.
        step(4'b0100, 64'h0000_1111_0000_0000, 8'h40, 1'b1);
        step(4'b0100, 64'h0000_2222_0000_0000, 8'h40, 1'b1);
        step(4'b1011, 64'h0D0D_0000_0B0B_0A0A, 8'h40, 1'b1);
        idle(6);

        // Backpressure pattern during the drain.
        step(4'hF, 64'h4444_3333_2222_1111, 8'h80, 1'b0);
        begin
            logic [11:0] pat;
            pat = 12'b1110_1001_0010;
            for (int c = 0; c < 12; c++) step('0, '0, '0, pat[c]);
        end
        idle(2);

        // Valids held through the drain, then a new set captured immediately.
        step(4'hF, 64'h5004_5003_5002_5001, 8'h20, 1'b1);
        for (int c = 0; c < 5; c++) step(4'hF, 64'h6004_6003_6002_6001, 8'h30, 1'b1);
        rvalid = '0;
        idle(8);

        // Asynchronous reset in mid-drain.
        step(4'hF, 64'h7004_7003_7002_7001, 8'h50, 1'b1);
        step('0, '0, '0, 1'b1);
        step('0, '0, '0, 1'b1);
        rst = 1'b1;
        #1;
        check_zero("midreset");
        @(posedge clk); #1;
        rst = 1'b0;
        scen1();

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0]   v;
            logic [N*W-1:0] r;
            for (int i = 0; i < N; i++) begin
                v[i] = ($urandom_range(0, 3) == 0);
                r[i*W +: W] = W'($urandom);
            end
            step(v, r, AW'($urandom), ($urandom_range(0, 3) != 0));
        end
        idle(12);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fma_writeback_buffer.md
# fma_writeback_buffer

Collects one result word from each of the FMA_COUNT FMA lanes, then drains the collected results to memory one word per accepted beat over a valid/ready write port. It is the return path of the FMA array: operands fan out to the lanes through the operand buffer, and results come back through this block. Results arrive from lanes in any order and over any number of cycles. Memory sees a strictly ordered burst at consecutive addresses.

## Interface
Parameters:
- WIDTH, 16: bits per result word.
- FMA_COUNT, 4: number of FMA lanes.
- ADDR_WIDTH, 8: memory word-address width.

Ports:
- clk_in  input  1  system clock; all state changes on the rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- result_in  input  FMA_COUNT*WIDTH  packed lane results; lane i occupies bits [i*WIDTH +: WIDTH].
- result_valid_in  input  FMA_COUNT  per-lane valid; bit i qualifies lane i.
- base_addr_in  input  ADDR_WIDTH  write address for lane 0; sampled on the capture edge that completes collection.
- data_out  output  WIDTH  write data for the current beat.
- addr_out  output  ADDR_WIDTH  write address for the current beat.
- valid_out  output  1  write beat is valid.
- ready_in  input  1  memory accepts the beat.
- busy_out  output  1  high while in DRAIN.
- drop_out  output  1  one-cycle pulse: at least one lane valid was discarded this cycle.

## Operation
- Two states, held in a state enum: COLLECT (reset state) and DRAIN.
- COLLECT:
  - For each lane i with result_valid_in[i]=1 and full[i]=0, capture the word into slot i and set full[i].
  - If a valid arrives for a lane whose full bit is already set, the first value is kept and drop_out pulses on the next cycle.
  - On the edge where all full bits become set (including when several lanes complete together), the block:
    - latches base_addr_in,
    - moves to DRAIN,
    - sets lane index to 0,
    - asserts valid_out with data_out=slot[0] and addr_out=base.
- DRAIN:
  - Every result_valid_in bit is discarded. drop_out pulses on the next cycle if any bit was set.
  - A beat transfers on an edge with valid_out=1 and ready_in=1. On each transfer, the index increments and data_out/addr_out update on the same edge.
  - addr_out = base + index, modulo 2^ADDR_WIDTH (wraps silently).
  - Transfer of beat FMA_COUNT-1 sends the block back to COLLECT: all full bits clear, valid_out drops, index returns to 0.
  - When ready_in=0, valid_out, data_out and addr_out hold stable.
- Slot contents are not cleared on return to COLLECT; only the full bits are.

## Timing
- Reset values (asynchronous, take effect immediately):
  - state = COLLECT.
  - All full bits = 0; index = 0.
  - valid_out=0, busy_out=0, drop_out=0, data_out=0, addr_out=0.
- Reset in mid-drain abandons the burst. No further beats are issued.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency: last lane captured on edge N means valid_out=1 from edge N onward. With ready_in held high, the burst occupies FMA_COUNT consecutive cycles.
- Return to COLLECT: the next lane capture can happen at the edge after the final beat transfers. A result_valid_in presented during the final-beat cycle is dropped.
- busy_out equals (state==DRAIN). It is high during exactly the same cycles as valid_out.
- Collection has no timeout. A lane that never reports keeps the block in COLLECT indefinitely.

## Structure
- Shared package fma_pkg holds:
  - the wb_state_t enum {COLLECT, DRAIN},
  - the default WIDTH and FMA_COUNT constants, shared with the operand buffer.
- Single module; no sub-module. Slot storage is a FMA_COUNT-entry register array indexed by the $clog2(FMA_COUNT)-bit lane index.
- Every piece of state sits on one always_ff block triggered by posedge clk_in or posedge rst_in.

## Test plan
1. Lanes 0..3 report 16'h0011, 16'h0022, 16'h0033, 16'h0044 on four separate cycles, base_addr_in=8'h10, ready_in=1 -> valid_out rises the cycle after the lane-3 capture. Beats are (10,0011), (11,0022), (12,0033), (13,0044). valid_out and busy_out then fall.
2. All four lanes valid together with 16'hA000+i, base 8'hFE -> the burst starts the next cycle. Addresses are FE, FF, 00, 01 (wrap).
3. Lane 2 reports 16'h1111, then 16'h2222 before collection completes -> drop_out pulses once. Beat 2 carries 16'h1111.
4. ready_in toggles 0,1,0,0,1,... during a drain -> data_out and addr_out stay stable while ready_in=0. All four beats are delivered exactly once, in order.
5. result_valid_in=4'hF asserted throughout a drain -> drop_out pulses each cycle. The next collection starts empty and completes on the first edge after the return to COLLECT.
6. rst_in pulsed after beat 1 of a drain -> valid_out, busy_out and all outputs go to 0 immediately. A fresh four-lane collection then behaves as in scenario 1.
